// File: rtl/fsqrt_arb_pkg.sv
// Shared types and helpers for the fsqrt request arbiter.
package fsqrt_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Canonical quiet NaN returned for negative operands on the fast path.
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
  } fp_se_t;

  // Sign and biased exponent of an IEEE-754 single.
  function automatic fp_se_t fp_sign_exp(input logic [31:0] x);
    fp_se_t se;
    se.sign = x[31];
    se.exp  = x[30:23];
    return se;
  endfunction

endpackage

// File: rtl/fsqrt_arbiter_rr.sv
// Combinational round-robin search: first set request at or above the
// pointer, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  // Walk the requests starting at the pointer; the first hit wins.
  always_comb begin : search
    int j;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(i_ptr) + k) % NREQ;
      if (!o_any && i_req[j]) begin
        o_any      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/fsqrt_arbiter.sv
// Shares one non-pipelined fsqrt datapath between NREQ requesters.
// Round-robin grant in IDLE, operand held on sq_x for LATENCY cycles in
// WAIT, tagged result presented with valid/ready in RESP.
// Optional: FSQRT_ARB_FASTPATH_EN answers zero/denormal and negative
// operands directly from IDLE without using the datapath.
module fsqrt_arbiter
  import fsqrt_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*32-1:0] req_x,
  output logic [NREQ-1:0]    req_ready,
  output logic               resp_valid,
  output logic [IDW-1:0]     resp_id,
  output logic [31:0]        resp_res,
  input  logic               resp_ready,
  output logic [31:0]        sq_x,
  input  logic [31:0]        sq_res,
  output logic               busy
);

  // LATENCY-1 always fits in clog2(LATENCY) bits for LATENCY >= 2.
  localparam int CNT_W = $clog2(LATENCY);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_sq_x;
  logic [IDW-1:0]   r_id_q;
  logic [IDW-1:0]   r_rr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_resp_valid;
  logic [IDW-1:0]   r_resp_id;
  logic [31:0]      r_resp_res;

  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_gidx;
  logic             w_any;
  logic [31:0]      w_sel_x;
  logic             w_take;
  logic             w_fast;
  logic [31:0]      w_fast_res;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_rr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  // Select the granted requester's operand.
  always_comb begin
    w_sel_x = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gidx == IDW'(i)) w_sel_x = req_x[32*i +: 32];
    end
  end

  // Next-state logic; fast-path classification only exists when enabled.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_fast      = 1'b0;
    w_fast_res  = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_take = 1'b1;
`ifdef FSQRT_ARB_FASTPATH_EN
          if (fp_sign_exp(w_sel_x).exp == 8'd0) begin
            w_fast     = 1'b1;
            w_fast_res = {w_sel_x[31], 31'b0};
          end else if (fp_sign_exp(w_sel_x).sign) begin
            w_fast     = 1'b1;
            w_fast_res = QNAN;
          end
`endif
          w_state_nxt = w_fast ? RESP : WAIT;
        end
      end
      WAIT:    if (r_cnt == '0) w_state_nxt = RESP;
      RESP:    if (resp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; reset mid-operation abandons the operation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Operand, counter, pointer and response registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sq_x       <= '0;
      r_id_q       <= '0;
      r_rr         <= '0;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_res   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_id_q <= w_gidx;
            r_rr   <= (w_gidx == IDW'(NREQ-1)) ? '0 : w_gidx + 1'b1;
            if (w_fast) begin
              r_resp_res   <= w_fast_res;
              r_resp_id    <= w_gidx;
              r_resp_valid <= 1'b1;
            end else begin
              r_sq_x <= w_sel_x;
              r_cnt  <= CNT_W'(LATENCY-1);
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_resp_res   <= sq_res;
            r_resp_id    <= r_id_q;
            r_resp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) r_resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE) ? w_grant : '0;
  assign busy       = (r_state != IDLE);
  assign sq_x       = r_sq_x;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_res   = r_resp_res;

endmodule

// File: doc/fsqrt_arbiter.md
Name: fsqrt_arbiter

Overview:
- Shares one combinational-plus-ROM `fsqrt` datapath between NREQ requesters, e.g. the FPU issue slots or the simulator test harness ports.
- Arbitrates round-robin, latches the winning operand, and holds it stable on the datapath for LATENCY cycles.
- Captures the result and returns it on a single tagged response channel with valid/ready.
- Exactly one operation is in flight at a time; the datapath is not pipelined.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester id; must be at least clog2(NREQ).
- LATENCY, 2, cycles the operand is held on sq_x before sq_res is sampled (at least 2, because the ROM read is registered).

Ports:
- clk  in  1  system clock; all state on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_x  in  NREQ*32  packed operands; requester i uses bits [32*i+31:32*i].
- req_ready  out  NREQ  one-hot accept strobe, combinational from grant.
- resp_valid  out  1  result valid.
- resp_id  out  IDW  index of the requester that owns the result.
- resp_res  out  32  IEEE-754 single result.
- resp_ready  in  1  consumer accepts the result.
- sq_x  out  32  operand to the fsqrt datapath, registered.
- sq_res  in  32  result from the fsqrt datapath.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset, asynchronous on rstn low:
  - state goes to IDLE.
  - sq_x=0, resp_valid=0, resp_id=0, resp_res=0.
  - rr pointer=0, counter=0.
  - A reset in the middle of an operation discards that operation; no response is produced for it.
- State IDLE:
  - Grant the first requester with req_valid set, searching from rr pointer upward and wrapping modulo NREQ.
  - req_ready[g]=1 for that one cycle only; req_ready is all-zero in every other state.
  - On a grant: sq_x<=req_x[g], id_q<=g, rr<=(g+1) mod NREQ, cnt<=LATENCY-1, then go to WAIT.
  - With no req_valid set, stay in IDLE and leave rr unchanged.
- State WAIT:
  - sq_x is held constant.
  - cnt decrements each cycle.
  - When cnt==0: resp_res<=sq_res, resp_id<=id_q, resp_valid<=1, then go to RESP.
  - Result: resp_valid rises exactly LATENCY+1 cycles after the req_ready cycle.
- State RESP:
  - resp_valid, resp_id and resp_res are held stable until resp_ready is sampled high.
  - On that edge resp_valid<=0 and the state returns to IDLE; the next grant happens no earlier than the following cycle.
  - When resp_valid and resp_ready are both high in the same cycle that new requests arrive, the transfer completes first; requests are considered from IDLE only.
- Throughput: one operation every LATENCY+2 cycles at best.
- Fairness: a requester holding req_valid continuously is served within NREQ operations.
- The arbiter never inspects operand values; all special-case handling is the datapath's job unless the optional feature is compiled in.
- Requesters must keep req_x stable while req_valid is high and req_ready is low.

Optional Feature:
- Macro: FSQRT_ARB_FASTPATH_EN.
- When defined, the IDLE grant examines the operand:
  - Exponent==0 (zero or denormal): result is {sign,31'b0}.
  - Sign==1 with nonzero exponent: result is 32'h7FC00000 (canonical NaN).
  - For both cases the arbiter loads resp_* directly and goes IDLE->RESP, skipping WAIT; response latency is 1 cycle.
  - sq_x is not updated for fast-path operands.
- When undefined, every operand goes through WAIT and sq_res is returned unmodified.

Decomposition:
- Package fsqrt_arb_pkg holds:
  - state enum: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - constant QNAN=32'h7FC00000.
  - a function that extracts sign and exponent from a 32-bit float.
- One sub-module, rr_arbiter: parameterised NREQ, with inputs req vector and rr pointer, and outputs one-hot grant, encoded index and any-grant flag. Purely combinational.
- The FSM, the counter and the datapath registers stay in fsqrt_arbiter.

Test Plan:
- Single request, LATENCY=2, NREQ=4, req 1 with x=32'h40800000 (4.0), datapath model returns 32'h40000000 -> req_ready[1] pulses once; resp_valid 3 cycles later with resp_id=1, resp_res=32'h40000000.
- All four requesters valid continuously from reset -> grants in order 0,1,2,3,0; each response id matches its grant.
- Back-pressure: hold resp_ready=0 for 5 cycles -> resp_valid, resp_id and resp_res stay stable, no new req_ready; release -> IDLE on the next cycle, then the next grant.
- Reset asserted during WAIT -> resp_valid=0, busy=0, rr=0 immediately; after release the lowest valid requester is granted first.
- FSQRT_ARB_FASTPATH_EN defined:
  - x=32'hBF800000 -> resp_res=32'h7FC00000 one cycle after the grant.
  - x=32'h80000000 -> resp_res=32'h80000000.
  - sq_x is unchanged in both cases.
- Requester 2 held valid while requester 0 toggles every operation -> requester 2 is served at least once every 2 operations.
